store_buffer: RTL

//  - Posted-write buffer between the MEM-stage datapath and data_memory.
//  - Accepts stores in one cycle and drains them into data_memory one per idle cycle.
//  - Loads get priority on the memory port and see buffered data through store-to-load forwarding.
//  - Flush handshake empties the buffer before syscall/halt/memory dump.

---
 rtl/mips_mem_pkg.sv | 10 +
 rtl/sb_fwd_match.sv | 34 +++
 rtl/store_buffer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants and state encodings for the MEM-stage posted-write path.
package mips_mem_pkg;
    localparam int WORD_W   = 32;
    localparam int SB_DEPTH = 4;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_FLUSH = 1'b1
    } sb_state_t;
endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding: compare a load address against every live entry,
// youngest entry (just behind wr_ptr) wins.
module sb_fwd_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic [DEPTH-1:0][WORD_W-1:0] ent_addr,
    input  logic [DEPTH-1:0][WORD_W-1:0] ent_data,
    input  logic [DEPTH-1:0]             ent_vld,
    input  logic [$clog2(DEPTH)-1:0]     wr_ptr,
    input  logic [WORD_W-1:0]            ld_addr,
    output logic                         hit,
    output logic [WORD_W-1:0]            data
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a younger match overrides an older one.
    // k+1 == DEPTH truncates to 0, i.e. the slot at wr_ptr (oldest when full).
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = wr_ptr - PW'(k + 1);
            if (ent_vld[idx] && ent_addr[idx] == ld_addr) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and data_memory: stores drain on
// cycles without a load, loads forward from buffered stores.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [WORD_W-1:0]          st_addr,
    input  logic [WORD_W-1:0]          st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [WORD_W-1:0]          ld_addr,
    output logic [WORD_W-1:0]          ld_data,
    output logic                       ld_fwd,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WORD_W-1:0]          mem_address,
    output logic                       mem_memWrite,
    output logic [WORD_W-1:0]          mem_writeData,
    input  logic [WORD_W-1:0]          mem_readData
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][WORD_W-1:0] ent_addr;
    logic [DEPTH-1:0][WORD_W-1:0] ent_data;
    logic [DEPTH-1:0]             ent_vld;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [CW-1:0]                cnt;
    logic [CW-1:0]                cnt_nxt;
    sb_state_t                    state;
    logic                         full;
    logic                         enq;
    logic                         deq;
    logic                         fwd_hit;
    logic [WORD_W-1:0]            fwd_data;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign st_ready = !full && (state == SB_RUN);
    assign enq      = st_valid && st_ready;
    assign deq      = !ld_valid && !empty;
    assign cnt_nxt  = cnt + CW'(enq) - CW'(deq);

    // Loads own the port; otherwise the head entry drains.
    always_comb begin
        mem_address   = '0;
        mem_memWrite  = 1'b0;
        mem_writeData = '0;
        if (ld_valid) begin
            mem_address = ld_addr;
        end else if (!empty) begin
            mem_address   = ent_addr[rd_ptr];
            mem_writeData = ent_data[rd_ptr];
            mem_memWrite  = 1'b1;
        end
    end

    // Payload needs no reset: ent_vld gates every use of it.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[wr_ptr] <= st_addr;
            ent_data[wr_ptr] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ent_vld <= '0;
        end else begin
            if (deq) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (enq) begin
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            cnt <= cnt_nxt;
        end
    end

    // A flush that finds nothing left after this edge completes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SB_RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                SB_RUN: begin
                    if (flush_req) begin
                        if (cnt_nxt == '0) flush_done <= 1'b1;
                        else               state      <= SB_FLUSH;
                    end
                end
                SB_FLUSH: begin
                    if (cnt_nxt == '0) begin
                        state      <= SB_RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= SB_RUN;
            endcase
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .ent_vld  (ent_vld),
        .wr_ptr   (wr_ptr),
        .ld_addr  (ld_addr),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    assign ld_fwd  = ld_valid && fwd_hit;
    assign ld_data = ld_fwd ? fwd_data : mem_readData;
endmodule
